// File: rtl/pwm_ramp_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ramp_ctrl_if
//  Description : Target-duty handshake between a requester (master) and the
//                PWM ramp controller (slave). A target, step size and
//                periods-per-step divider travel together under one
//                valid/ready pair.
//  Signals     : tgt_valid  master->slave  new target offered
//                tgt_ready  slave->master  controller idle, can accept
//                tgt_duty   master->slave  target duty
//                step       master->slave  duty increment per step
//                div        master->slave  PWM periods per step (0 == 1)
//  Revision    : 1.0  initial release
// ============================================================================
interface pwm_ramp_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4,
  parameter int DIV_W  = 8
);
  logic              tgt_valid;
  logic              tgt_ready;
  logic [WIDTH-1:0]  tgt_duty;
  logic [STEP_W-1:0] step;
  logic [DIV_W-1:0]  div;

  modport master (
    output tgt_valid,
    output tgt_duty,
    output step,
    output div,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_duty,
    input  step,
    input  div,
    output tgt_ready
  );
endinterface
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ramp_ctrl
//  Description : Duty-cycle sequencer for the PWM block. Accepts a target duty
//                over a valid/ready handshake, then slews its duty output
//                toward the target by a programmable step. Duty only changes
//                on the edge where the period counter wraps MAX->0, so no PWM
//                period is ever truncated. The period counter is owned here
//                and exported.
//  Ports       : clk      clock
//                rst      asynchronous, active-high reset
//                tgt      target handshake (slave side of pwm_ramp_ctrl_if)
//                duty     current duty, drives the PWM compare input
//                pwm_cnt  free-running period counter (period = 2**WIDTH)
//                busy     ramp in progress
//                done     one-cycle pulse when duty reaches the target
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_ramp_ctrl #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  pwm_ramp_ctrl_if.slave    tgt,
  output logic [WIDTH-1:0]  duty,
  output logic [WIDTH-1:0]  pwm_cnt,
  output logic              busy,
  output logic              done
);

  localparam logic [WIDTH-1:0] C_CNT_MAX = {WIDTH{1'b1}};
  localparam logic [DIV_W-1:0] C_DIV_ONE = DIV_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  state_t              state_q,   state_d;
  logic [WIDTH-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0]    duty_q,    duty_d;
  logic [WIDTH-1:0]    tgt_q,     tgt_d;
  logic [STEP_W-1:0]   step_q,    step_d;
  logic [DIV_W-1:0]    div_q,     div_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                done_q,    done_d;

  logic                period_end;
  logic [WIDTH:0]      step_ext;
  logic [WIDTH:0]      up_sum;
  logic [WIDTH:0]      dn_diff;
  logic [WIDTH-1:0]    step_duty;
  logic [DIV_W-1:0]    div_eff;

  assign period_end = (cnt_q == C_CNT_MAX);

  // A divider of 0 behaves exactly like 1.
  assign div_eff = (tgt.div == '0) ? C_DIV_ONE : tgt.div;

  // Next duty for one step. The arithmetic is one bit wider than the duty so
  // that overflow above MAX and underflow below 0 are visible and can be
  // clamped to the target instead of wrapping.
  always_comb begin
    step_ext  = (WIDTH+1)'(step_q);
    up_sum    = {1'b0, duty_q} + step_ext;
    dn_diff   = {1'b0, duty_q} - step_ext;
    step_duty = tgt_q;
    if (step_q != '0) begin
      if (tgt_q > duty_q) begin
        if (up_sum < {1'b0, tgt_q}) begin
          step_duty = up_sum[WIDTH-1:0];
        end
      end else begin
        // dn_diff[WIDTH] set means the subtraction went below zero.
        if (!dn_diff[WIDTH] && (dn_diff > {1'b0, tgt_q})) begin
          step_duty = dn_diff[WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    cnt_d     = cnt_q + WIDTH'(1);
    state_d   = state_q;
    duty_d    = duty_q;
    tgt_d     = tgt_q;
    step_d    = step_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // tgt_ready is high throughout IDLE, so valid alone is an accept.
        if (tgt.tgt_valid) begin
          tgt_d     = tgt.tgt_duty;
          step_d    = tgt.step;
          div_d     = div_eff;
          div_cnt_d = div_eff;
          if (tgt.tgt_duty == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RAMP;
          end
        end
      end

      ST_RAMP: begin
        if (period_end) begin
          // A count of 1 means this period_end is the one that hits zero.
          if (div_cnt_q <= C_DIV_ONE) begin
            duty_d    = step_duty;
            div_cnt_d = div_q;
            if (step_duty == tgt_q) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            div_cnt_d = div_cnt_q - C_DIV_ONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      duty_q    <= '0;
      tgt_q     <= '0;
      step_q    <= '0;
      div_q     <= '0;
      div_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      tgt_q     <= tgt_d;
      step_q    <= step_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      done_q    <= done_d;
    end
  end

  // Handshake and status are pure state decodes; no input reaches them
  // combinationally.
  assign tgt.tgt_ready = (state_q == ST_IDLE);
  assign busy          = (state_q == ST_RAMP);
  assign duty          = duty_q;
  assign pwm_cnt       = cnt_q;
  assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_ramp_ctrl
//  Description : Directed self-checking bench for pwm_ramp_ctrl. Expected
//                duties are hand-computed per PWM period wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_ramp_ctrl;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 6;
  localparam int DIV_W  = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] pwm_cnt;
  logic             busy;
  logic             done;

  int n_checks;
  int n_pass;

  pwm_ramp_ctrl_if #(.WIDTH(WIDTH), .STEP_W(STEP_W), .DIV_W(DIV_W)) tgt_if ();

  pwm_ramp_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W), .DIV_W(DIV_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .tgt     (tgt_if.slave),
    .duty    (duty),
    .pwm_cnt (pwm_cnt),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Wait for the next pwm_cnt wrap to 0, then check duty/done/busy.
  task automatic expect_wrap(input string tag, input logic [7:0] exp_duty,
                             input logic exp_done, input logic exp_busy);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (pwm_cnt == '0) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_wrap_seen"}, found, 1'b1);
    check({tag, "_duty"}, duty, exp_duty);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_busy"}, busy, exp_busy);
  endtask

  // Offer one target for one cycle; the controller must be idle.
  task automatic accept(input logic [7:0] t, input logic [5:0] s, input logic [7:0] d);
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_duty  = t;
    tgt_if.step      = s;
    tgt_if.div       = d;
    check("ready_at_accept", tgt_if.tgt_ready, 1'b1);
    @(posedge clk); #1;
    tgt_if.tgt_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst              = 1'b1;
    tgt_if.tgt_valid = 1'b0;
    tgt_if.tgt_duty  = '0;
    tgt_if.step      = '0;
    tgt_if.div       = '0;
    #22 rst = 1'b0;

    // 1: asynchronous reset between edges
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_cnt",   pwm_cnt, 0);
    check("rst_duty",  duty, 0);
    check("rst_busy",  busy, 0);
    check("rst_ready", tgt_if.tgt_ready, 1);
    check("rst_done",  done, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // 2: ramp up 0 -> 64 by 16
    accept(8'd64, 6'd16, 8'd1);
    check("t2_busy_after_accept",  busy, 1);
    check("t2_ready_after_accept", tgt_if.tgt_ready, 0);
    expect_wrap("t2_s1", 8'd16, 1'b0, 1'b1);
    expect_wrap("t2_s2", 8'd32, 1'b0, 1'b1);
    expect_wrap("t2_s3", 8'd48, 1'b0, 1'b1);
    expect_wrap("t2_s4", 8'd64, 1'b1, 1'b0);
    check("t2_ready_on_done", tgt_if.tgt_ready, 1);

    // 3: ramp down with clamp, then top-end clamp
    accept(8'd10, 6'd20, 8'd1);
    expect_wrap("t3_d1", 8'd44, 1'b0, 1'b1);
    expect_wrap("t3_d2", 8'd24, 1'b0, 1'b1);
    expect_wrap("t3_d3", 8'd10, 1'b1, 1'b0);
    accept(8'd240, 6'd0, 8'd1);
    expect_wrap("t3_j240", 8'd240, 1'b1, 1'b0);
    accept(8'd250, 6'd15, 8'd1);
    expect_wrap("t3_u250", 8'd250, 1'b1, 1'b0);

    // 4: div=3 steps every third wrap; div=0 behaves as div=1
    accept(8'd190, 6'd20, 8'd3);
    for (int k = 0; k < 9; k++) begin
      expect_wrap("t4_div3", 8'(250 - 20 * ((k + 1) / 3)), (k == 8), (k != 8));
    end
    accept(8'd170, 6'd20, 8'd0);
    expect_wrap("t4_div0_a", 8'd170, 1'b1, 1'b0);
    accept(8'd130, 6'd20, 8'd0);
    expect_wrap("t4_div0_b1", 8'd150, 1'b0, 1'b1);
    expect_wrap("t4_div0_b2", 8'd130, 1'b1, 1'b0);

    // 5: step=0 jumps; equal target completes immediately
    accept(8'd0, 6'd0, 8'd1);
    expect_wrap("t5_j0", 8'd0, 1'b1, 1'b0);
    accept(8'd200, 6'd0, 8'd1);
    expect_wrap("t5_j200", 8'd200, 1'b1, 1'b0);
    accept(8'd200, 6'd5, 8'd1);
    check("t5_eq_done",  done, 1);
    check("t5_eq_busy",  busy, 0);
    check("t5_eq_ready", tgt_if.tgt_ready, 1);
    @(posedge clk); #1;
    check("t5_eq_done_pulse", done, 0);
    check("t5_eq_duty",       duty, 200);

    // 6: valid held during RAMP is ignored, then taken right after done
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_duty  = 8'd100;
    tgt_if.step      = 6'd50;
    tgt_if.div       = 8'd1;
    @(posedge clk); #1;
    tgt_if.tgt_duty  = 8'd30;
    check("t6_busy", busy, 1);
    expect_wrap("t6_a1", 8'd150, 1'b0, 1'b1);
    expect_wrap("t6_a2", 8'd100, 1'b1, 1'b0);
    @(posedge clk); #1;
    tgt_if.tgt_valid = 1'b0;
    check("t6_second_accepted", busy, 1);
    expect_wrap("t6_b1", 8'd50, 1'b0, 1'b1);
    expect_wrap("t6_b2", 8'd30, 1'b1, 1'b0);

    // 6: reset in the middle of a ramp
    accept(8'd200, 6'd10, 8'd1);
    expect_wrap("t6_c1", 8'd40, 1'b0, 1'b1);
    repeat (50) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t6_rst_duty",  duty, 0);
    check("t6_rst_cnt",   pwm_cnt, 0);
    check("t6_rst_busy",  busy, 0);
    check("t6_rst_ready", tgt_if.tgt_ready, 1);
    check("t6_rst_done",  done, 0);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_post_rst_busy", busy, 0);
    check("t6_post_rst_duty", duty, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
